// File: rtl/ttl_pkg.sv
// Shared definitions for the TTL-equivalent counter models (ls161, ls169, ...).
// Holds the default counter width and the count-direction encoding.
package ttl_pkg;

  localparam int TTL_CNT_W = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } cnt_dir_e;

endpackage

// File: rtl/ls169_tc.sv
// Terminal-count detect for up/down counters: all-ones when counting up,
// zero when counting down, gated by the trickle enable. Purely combinational.
module ls169_tc
  import ttl_pkg::*;
#(
  parameter int WIDTH = TTL_CNT_W
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic             ent,
  output logic             rco
);

  logic tc;

  always_comb begin
    tc  = up ? (&q) : ~(|q);
    rco = ent & tc;
  end

endmodule

// File: rtl/ls169.sv
// Synchronous presettable up/down binary counter (74LS169 function) with
// asynchronous clear and enp/ent/rco cascading compatible with ls161.
module ls169
  import ttl_pkg::*;
#(
  parameter int WIDTH = TTL_CNT_W
) (
  input  logic             clk,
  input  logic             n_clr,
  input  logic [WIDTH-1:0] din,
  input  logic             n_load,
  input  logic             enp,
  input  logic             ent,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             rco
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Load beats counting; counting wraps modulo 2^WIDTH in both directions.
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      q <= '0;
    end else if (!n_load) begin
      q <= din;
    end else if (enp && ent) begin
      q <= up ? (q + ONE) : (q - ONE);
    end
  end

  // rco follows q, up and ent with no register, so cascades see carry in the same cycle.
  ls169_tc #(
    .WIDTH (WIDTH)
  ) u_tc (
    .q   (q),
    .up  (up),
    .ent (ent),
    .rco (rco)
  );

endmodule

// File: tb/tb_ls169.sv
// Bench for ls169: two 4-bit stages chained into an 8-bit counter, checked
// against a plain 8-bit arithmetic model of the counter behaviour.
module tb_ls169;
  import ttl_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_clr;
  logic [7:0] din;
  logic       n_load, enp, ent, up;
  logic [3:0] q_lo, q_hi;
  logic       rco_lo, rco_hi;

  ls169 #(.WIDTH(4)) u_lo (
    .clk    (clk),
    .n_clr  (n_clr),
    .din    (din[3:0]),
    .n_load (n_load),
    .enp    (enp),
    .ent    (ent),
    .up     (up),
    .q      (q_lo),
    .rco    (rco_lo)
  );

  ls169 #(.WIDTH(4)) u_hi (
    .clk    (clk),
    .n_clr  (n_clr),
    .din    (din[7:4]),
    .n_load (n_load),
    .enp    (enp),
    .ent    (rco_lo),
    .up     (up),
    .q      (q_hi),
    .rco    (rco_hi)
  );

  // scoreboard: expected 8-bit chain value
  logic [7:0] m;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic tc4, tc8;
    tc4 = up ? (m[3:0] == 4'hF) : (m[3:0] == 4'h0);
    tc8 = up ? (m == 8'hFF) : (m == 8'h00);
    check({tag, ".q_lo"},   32'(q_lo),   32'(m[3:0]));
    check({tag, ".q_hi"},   32'(q_hi),   32'(m[7:4]));
    check({tag, ".rco_lo"}, 32'(rco_lo), 32'(ent & tc4));
    check({tag, ".rco_hi"}, 32'(rco_hi), 32'(ent & tc8));
  endtask

  // driver: one rising edge with n_clr high, model advanced by the counter rules
  task automatic tick(input string tag);
    logic [7:0] nm;
    if (!n_load)           nm = din;
    else if (enp && ent)   nm = up ? m + 8'd1 : m - 8'd1;
    else                   nm = m;
    @(posedge clk);
    #1;
    m = nm;
    check_all(tag);
  endtask

  initial begin
    n_clr  = 1'b0;
    din    = 8'h00;
    n_load = 1'b1;
    enp    = 1'b1;
    ent    = 1'b1;
    up     = DIR_UP;
    m      = 8'h00;

    // reset: q zero, rco low while counting up from 0
    #1;
    check_all("rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("rst_hold");
    up = DIR_DOWN;
    #1;
    check_all("rst_down_rco");
    @(negedge clk);
    n_clr = 1'b1;
    #1;
    check_all("rst_release");

    // up count through wrap
    up = DIR_UP;
    for (int i = 0; i < 18; i++) tick("up");

    // down count through wrap
    din = 8'h02; n_load = 1'b0;
    tick("load2");
    n_load = 1'b1; up = DIR_DOWN;
    #1;
    check_all("down_pre");
    for (int i = 0; i < 4; i++) tick("down");

    // load has priority over count
    din = 8'h0A; n_load = 1'b0; up = DIR_UP; enp = 1'b1; ent = 1'b1;
    tick("load_pri");
    n_load = 1'b1;
    tick("after_load");

    // enable gating at terminal count
    din = 8'h0F; n_load = 1'b0;
    tick("loadF");
    n_load = 1'b1; enp = 1'b0; ent = 1'b1;
    tick("enp_off");
    ent = 1'b0;
    #1;
    check_all("ent_off_rco");
    tick("ent_off");

    // async clear between edges
    enp = 1'b1; ent = 1'b1; din = 8'h07; n_load = 1'b0;
    tick("load7");
    n_load = 1'b1;
    #3 n_clr = 1'b0;
    #1 m = 8'h00;
    check_all("async_clr");
    #4 n_clr = 1'b1;
    tick("after_clr");

    // cascade borrow: 0x00 down to 0xFF
    din = 8'h00; n_load = 1'b0;
    tick("load00");
    n_load = 1'b1; up = DIR_DOWN;
    #1;
    check_all("casc_pre");
    tick("casc_borrow");

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      din    = 8'($urandom_range(0, 255));
      n_load = ($urandom_range(0, 7) != 0);
      enp    = ($urandom_range(0, 3) != 0);
      ent    = ($urandom_range(0, 3) != 0);
      up     = 1'($urandom_range(0, 1));
      #1;
      check_all("rnd_comb");
      if ($urandom_range(0, 19) == 0) begin
        n_clr = 1'b0;
        #1 m = 8'h00;
        check_all("rnd_clr");
        #3 n_clr = 1'b1;
      end
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
